// File: rtl/fletcher_framer.sv
// Stream framer: forwards payload words, drives the Fletcher checksum stage, then appends checksum hi/lo words. Latency: in->out 1 cycle.
// Checksum hi is valid FlushLen+1 cycles after the last payload word. in_ready follows the output register; flush ignores out_ready.
// Optional length word before the checksum when FLETCHER_FRAMER_LEN_EN is defined.
module fletcher_framer #(
    parameter int Width    = 32,
    parameter int FlushLen = 2,
    localparam int WidthHalf = Width / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WidthHalf-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WidthHalf-1:0] out_data,
    output logic                 out_last,
    output logic                 ck_rst,
    output logic                 ck_en,
    output logic [WidthHalf-1:0] ck_din,
    input  logic [Width-1:0]     ck_dout
);

    localparam int FcW = (FlushLen > 1) ? $clog2(FlushLen) : 1;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_PAYLOAD,
        S_FLUSH,
        S_SUM_LEN,
        S_SUM_HI,
        S_SUM_LO
    } state_t;

    state_t               state_q, state_d;
    logic [FcW-1:0]       flush_cnt;
    logic                 flush_done;
    logic                 out_free;
    logic                 in_xfer;
    logic                 load;
    logic                 load_last;
    logic [WidthHalf-1:0] load_dat;

`ifdef FLETCHER_FRAMER_LEN_EN
    logic [15:0]          len_cnt;
`endif

    assign out_free   = !out_valid || out_ready;
    assign flush_done = (flush_cnt == FcW'(FlushLen - 1));
    assign in_xfer    = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        ck_rst    = 1'b0;
        ck_en     = 1'b0;
        ck_din    = '0;
        load      = 1'b0;
        load_last = 1'b0;
        load_dat  = '0;
        case (state_q)
            S_CLEAR: begin
                ck_rst  = 1'b1;
                state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                in_ready = out_free;
                if (in_valid && out_free) begin
                    ck_en    = 1'b1;
                    ck_din   = in_data;
                    load     = 1'b1;
                    load_dat = in_data;
                    if (in_last) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // zero words push the last payload word through the checksum pipeline
                ck_en = 1'b1;
                if (flush_done) begin
`ifdef FLETCHER_FRAMER_LEN_EN
                    state_d = S_SUM_LEN;
`else
                    state_d = S_SUM_HI;
`endif
                end
            end
`ifdef FLETCHER_FRAMER_LEN_EN
            S_SUM_LEN: begin
                if (out_free) begin
                    load     = 1'b1;
                    load_dat = WidthHalf'(len_cnt);
                    state_d  = S_SUM_HI;
                end
            end
`endif
            S_SUM_HI: begin
                if (out_free) begin
                    load     = 1'b1;
                    load_dat = ck_dout[Width-1:WidthHalf];
                    state_d  = S_SUM_LO;
                end
            end
            S_SUM_LO: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_last = 1'b1;
                    load_dat  = ck_dout[WidthHalf-1:0];
                    state_d   = S_CLEAR;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FLUSH && !flush_done) flush_cnt <= flush_cnt + FcW'(1);
            else                                   flush_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_dat;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef FLETCHER_FRAMER_LEN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    len_cnt <= '0;
        else if (state_q == S_CLEAR) len_cnt <= '0;
        else if (in_xfer)            len_cnt <= len_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fletcher_framer.sv
// Bench for fletcher_framer with a two-stage-pipelined Fletcher-32 model as the checksum stage.
module tb_fletcher_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [15:0] out_data;
    logic        ck_rst, ck_en;
    logic [15:0] ck_din;
    logic [31:0] ck_dout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ckrst_cnt = 0;

`ifdef FLETCHER_FRAMER_LEN_EN
    localparam int LenW = 1;
`else
    localparam int LenW = 0;
`endif

    fletcher_framer #(.Width(32), .FlushLen(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .ck_rst(ck_rst), .ck_en(ck_en), .ck_din(ck_din), .ck_dout(ck_dout)
    );

    always #5 clk = ~clk;

    // checksum stage model: din enters a two-deep pipe before reaching the sums
    logic [15:0] pipe0, pipe1, s1, s2;

    function automatic logic [15:0] add_mod(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= 17'd65535) t = t - 17'd65535;
        return t[15:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || ck_rst) begin
            pipe0 <= '0; pipe1 <= '0; s1 <= '0; s2 <= '0;
        end else if (ck_en) begin
            pipe0 <= ck_din;
            pipe1 <= pipe0;
            s1    <= add_mod(s1, pipe1);
            s2    <= add_mod(s2, add_mod(s1, pipe1));
        end
    end
    assign ck_dout = {s2, s1};

    logic [16:0] mq[$];
    int          mc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mq.push_back({out_last, out_data});
            mc.push_back(cyc);
        end
        if (!rst && ck_rst) ckrst_cnt++;
    end

    task automatic send_word(input logic [15:0] d, input logic l, output bit ok);
        ok = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    endtask

    task automatic wait_words(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (mq.size() >= n) ok = 1;
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 0; in_data = '0; in_last = 0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (ck_rst !== 1'b1) begin failures++; $display("FAIL reset_ck_rst got=%b exp=1", ck_rst); end
        checks++; if (ck_en !== 1'b0) begin failures++; $display("FAIL reset_ck_en got=%b exp=0", ck_en); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (ck_rst !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL clear_cycle ck_rst=%b in_ready=%b exp 1/0", ck_rst, in_ready); end
        @(negedge clk);
        checks++; if (ck_rst !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL payload_idle ck_rst=%b in_ready=%b exp 0/1", ck_rst, in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame;
        bit ok1, ok2, okw;
        logic [16:0] exp[$];
        int hi_i;
`ifdef FLETCHER_FRAMER_LEN_EN
        exp = '{17'h00001, 17'h00002, 17'h00002, 17'h00004, 17'h10003};
`else
        exp = '{17'h00001, 17'h00002, 17'h00004, 17'h10003};
`endif
        mq.delete(); mc.delete();
        out_ready = 1'b1;
        send_word(16'h0001, 1'b0, ok1);
        send_word(16'h0002, 1'b1, ok2);
        wait_words(exp.size(), okw);
        checks++; if (!(ok1 && ok2 && okw)) begin failures++; $display("FAIL basic_timeout send=%b%b words=%0d exp=%0d", ok1, ok2, mq.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= mq.size() || mq[i] !== exp[i]) begin
                failures++; $display("FAIL basic_word%0d got=%h exp=%h", i, (i < mq.size()) ? mq[i] : 17'h0, exp[i]);
            end
        end
        hi_i = 2 + LenW;
        if (mc.size() > hi_i) begin
            checks++;
            if (mc[hi_i] - mc[1] != 3 + LenW) begin
                failures++; $display("FAIL basic_hi_latency got=%0d exp=%0d", mc[hi_i] - mc[1], 3 + LenW);
            end
            checks++;
            if (mc[1] - mc[0] != 1) begin
                failures++; $display("FAIL basic_throughput got=%0d exp=1", mc[1] - mc[0]);
            end
        end
    endtask

    task automatic test_single_word;
        bit ok1, okw;
        logic [16:0] exp[$];
`ifdef FLETCHER_FRAMER_LEN_EN
        exp = '{17'h0FFFF, 17'h00001, 17'h00000, 17'h10000};
`else
        exp = '{17'h0FFFF, 17'h00000, 17'h10000};
`endif
        mq.delete(); mc.delete();
        send_word(16'hFFFF, 1'b1, ok1);
        wait_words(exp.size(), okw);
        checks++; if (!(ok1 && okw)) begin failures++; $display("FAIL single_timeout words=%0d exp=%0d", mq.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= mq.size() || mq[i] !== exp[i]) begin
                failures++; $display("FAIL single_word%0d got=%h exp=%h", i, (i < mq.size()) ? mq[i] : 17'h0, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok1, ok2, okw;
        logic [16:0] exp[$];
`ifdef FLETCHER_FRAMER_LEN_EN
        exp = '{17'h00001, 17'h00002, 17'h00002, 17'h00004, 17'h10003};
`else
        exp = '{17'h00001, 17'h00002, 17'h00004, 17'h10003};
`endif
        repeat (3) begin @(posedge clk); #1; end
        mq.delete(); mc.delete();
        out_ready = 1'b0;
        fork
            begin
                send_word(16'h0001, 1'b0, ok1);
                send_word(16'h0002, 1'b1, ok2);
            end
            begin
                for (int i = 0; i < 40; i++) begin @(posedge clk); #1 out_ready = ~out_ready; end
            end
            begin
                logic        pv;
                logic [15:0] pd;
                pv = 1'b0; pd = '0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (pv) begin
                        checks++;
                        if (out_valid !== 1'b1 || out_data !== pd) begin
                            failures++; $display("FAIL bp_hold valid=%b data=%h exp 1/%h", out_valid, out_data, pd);
                        end
                    end
                    if (out_valid && !out_ready) begin
                        checks++;
                        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
                    end
                    pv = out_valid && !out_ready;
                    pd = out_data;
                end
            end
        join
        out_ready = 1'b1;
        wait_words(exp.size(), okw);
        checks++; if (!(ok1 && ok2 && okw)) begin failures++; $display("FAIL bp_timeout words=%0d exp=%0d", mq.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= mq.size() || mq[i] !== exp[i]) begin
                failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, (i < mq.size()) ? mq[i] : 17'h0, exp[i]);
            end
        end
    endtask

    task automatic test_reset_in_flush;
        bit ok1, ok2, ok3, ok4, okw;
        logic [16:0] exp[$];
`ifdef FLETCHER_FRAMER_LEN_EN
        exp = '{17'h00001, 17'h00002, 17'h00002, 17'h00004, 17'h10003};
`else
        exp = '{17'h00001, 17'h00002, 17'h00004, 17'h10003};
`endif
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        send_word(16'h0005, 1'b0, ok1);
        send_word(16'h0002, 1'b1, ok2);
        @(negedge clk);
        checks++;
        if (ck_en !== 1'b1 || ck_din !== 16'h0 || out_valid !== 1'b1) begin
            failures++; $display("FAIL flush_state ck_en=%b ck_din=%h out_valid=%b exp 1/0000/1", ck_en, ck_din, out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || ck_en !== 1'b0) begin
            failures++; $display("FAIL rst_mid_frame out_valid=%b out_last=%b ck_en=%b exp 0/0/0", out_valid, out_last, ck_en);
        end
        @(posedge clk); #1 rst = 1'b0;
        mq.delete(); mc.delete();
        send_word(16'h0001, 1'b0, ok3);
        send_word(16'h0002, 1'b1, ok4);
        wait_words(exp.size(), okw);
        checks++; if (!(ok1 && ok2 && ok3 && ok4 && okw)) begin failures++; $display("FAIL rstflush_timeout words=%0d exp=%0d", mq.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= mq.size() || mq[i] !== exp[i]) begin
                failures++; $display("FAIL rstflush_word%0d got=%h exp=%h", i, (i < mq.size()) ? mq[i] : 17'h0, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok1, ok2, ok3, okw;
        int c0;
        logic [16:0] exp[$];
`ifdef FLETCHER_FRAMER_LEN_EN
        exp = '{17'h00001, 17'h00002, 17'h00002, 17'h00004, 17'h10003,
                17'h00010, 17'h00001, 17'h00010, 17'h10010};
`else
        exp = '{17'h00001, 17'h00002, 17'h00004, 17'h10003,
                17'h00010, 17'h00010, 17'h10010};
`endif
        repeat (3) begin @(posedge clk); #1; end
        mq.delete(); mc.delete();
        c0 = ckrst_cnt;
        send_word(16'h0001, 1'b0, ok1);
        send_word(16'h0002, 1'b1, ok2);
        send_word(16'h0010, 1'b1, ok3);
        wait_words(exp.size(), okw);
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (!(ok1 && ok2 && ok3 && okw)) begin failures++; $display("FAIL b2b_timeout words=%0d exp=%0d", mq.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= mq.size() || mq[i] !== exp[i]) begin
                failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, (i < mq.size()) ? mq[i] : 17'h0, exp[i]);
            end
        end
        checks++;
        if (ckrst_cnt - c0 != 2) begin failures++; $display("FAIL b2b_ck_rst_pulses got=%0d exp=2", ckrst_cnt - c0); end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_single_word;
        test_backpressure;
        test_reset_in_flush;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
